// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   state_t   : sequencer states (IDLE / ACCESS / RESP)
//   PORT_IF/LS: requester indices (instruction fetch / load-store)
//   cmd_t     : command latched on a request handshake
//   addr_err  : misaligned or out-of-range address check
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    // Word accesses must be 4-byte aligned and fall inside the attached memory.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned abits);
        return (addr[1:0] != 2'b00) || ((addr >> abits) != 32'd0);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker (purely combinational).
//   valid0/valid1 : request valids of port 0 / port 1
//   last_grant    : port granted on the previous handshake (held by the caller)
//   grant         : selected port index
//   any_valid     : at least one request is pending
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic any_valid
);

    always_comb begin
        any_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            // Tie: the port that did not win last time goes first.
            grant = ~last_grant;
        end else if (valid1) begin
            grant = PORT_LS;
        end else begin
            grant = PORT_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer in front of the shared word memory.
// Each accepted request takes three cycles: IDLE (handshake), ACCESS (one
// memory strobe cycle), RESP (one-cycle response pulse on the owning port).
//   clk, rst            : clock, synchronous active-high reset
//   mX_valid/ready      : request handshake per port
//   mX_we/addr/wdata    : request payload
//   mX_rvalid/rdata/err : registered response per port
//   mem_*               : memory access port (strobes active in ACCESS only)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_w_enb,
    output logic        mem_r_enb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_w_data,
    input  logic [31:0] mem_r_data
);

    state_t      state_reg, state_next;
    logic        last_grant_reg;
    cmd_t        cmd_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        grant;
    logic        any_valid;
    logic        handshake;
    logic        cmd_err;
    logic [1:0]  valid_vec;
    logic [1:0]  ready_vec;
    logic [1:0]  rvalid_vec;
    logic [1:0]  err_vec;
    logic [31:0] rdata_vec [2];

    rr_arb2 u_rr (
        .valid0     (m0_valid),
        .valid1     (m1_valid),
        .last_grant (last_grant_reg),
        .grant      (grant),
        .any_valid  (any_valid)
    );

    assign valid_vec = {m1_valid, m0_valid};
    assign cmd_err   = addr_err(cmd_reg.addr, ADDR_BITS);
    assign handshake = |(valid_vec & ready_vec);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign ready_vec[gi]  = (state_reg == IDLE) && !rst && any_valid
                                    && valid_vec[gi] && (grant == 1'(gi));
            // Responses are suppressed while rst is high so a dropped
            // transaction never produces a pulse.
            assign rvalid_vec[gi] = (state_reg == RESP) && !rst && (cmd_reg.port == 1'(gi));
            assign rdata_vec[gi]  = rvalid_vec[gi] ? rdata_reg : 32'd0;
            assign err_vec[gi]    = rvalid_vec[gi] & err_reg;
        end
    endgenerate

    assign m0_ready  = ready_vec[0];
    assign m1_ready  = ready_vec[1];
    assign m0_rvalid = rvalid_vec[0];
    assign m1_rvalid = rvalid_vec[1];
    assign m0_rdata  = rdata_vec[0];
    assign m1_rdata  = rdata_vec[1];
    assign m0_err    = err_vec[0];
    assign m1_err    = err_vec[1];

    always_comb begin
        state_next = state_reg;
        mem_w_enb  = 1'b0;
        mem_r_enb  = 1'b0;
        mem_addr   = 32'd0;
        mem_w_data = 32'd0;
        unique case (state_reg)
            IDLE: begin
                if (handshake) state_next = ACCESS;
            end
            ACCESS: begin
                state_next = RESP;
                if (!cmd_err && !rst) begin
                    mem_addr   = cmd_reg.addr;
                    mem_w_data = cmd_reg.wdata;
                    mem_w_enb  = cmd_reg.we;
                    mem_r_enb  = !cmd_reg.we;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= PORT_LS;
            cmd_reg        <= '0;
            rdata_reg      <= 32'd0;
            err_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (handshake) begin
                last_grant_reg <= grant;
                cmd_reg.port   <= grant;
                cmd_reg.we     <= grant ? m1_we    : m0_we;
                cmd_reg.addr   <= grant ? m1_addr  : m0_addr;
                cmd_reg.wdata  <= grant ? m1_wdata : m0_wdata;
            end
            if (state_reg == ACCESS) begin
                err_reg   <= cmd_err;
                rdata_reg <= (!cmd_err && !cmd_reg.we) ? mem_r_data : 32'd0;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the shared byte-addressed `memory` block. It accepts word read/write requests from two requesters, port 0 (instruction fetch) and port 1 (load/store unit), and grants them round-robin. It drives the memory's single access port for exactly one cycle per transaction and returns a registered response with an error flag. It sits between the core's fetch/LSU stages and the `memory` instance.

## Interface
- `ADDR_BITS`, 10: memory address width; must match the attached `memory` instance.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `m0_valid`, `m1_valid` input 1: request valid, per port.
- `m0_ready`, `m1_ready` output 1: request accepted this cycle when `valid && ready`.
- `m0_we`, `m1_we` input 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` input 32: byte address.
- `m0_wdata`, `m1_wdata` input 32: write data, little-endian.
- `m0_rvalid`, `m1_rvalid` output 1: one-cycle response pulse; sent for both reads and writes.
- `m0_rdata`, `m1_rdata` output 32: read data, valid with `rvalid`; 0 for writes and errors.
- `m0_err`, `m1_err` output 1: error flag, valid with `rvalid`.
- `mem_w_enb`, `mem_r_enb` output 1: memory strobes.
- `mem_addr`, `mem_w_data` output 32: memory address and write data.
- `mem_r_data` input 32: combinational read data from memory.

## Operation
- FSM states:
  - IDLE: arbitrate and accept.
  - ACCESS: drive memory.
  - RESP: pulse the response.
  - Transitions: IDLE→ACCESS on a handshake; ACCESS→RESP always; RESP→IDLE always.
- Arbitration, in IDLE only:
  - One requester valid: it is granted.
  - Both valid: the port not granted last wins.
  - `last_grant` updates on each handshake; its reset value is 1, so port 0 wins the first tie.
- `mX_ready` = IDLE && grant == X && !rst. It is combinational from state and both valids. It is never asserted to both ports in the same cycle.
- On a handshake, latch port id, we, addr and wdata into a command register.
- Requesters hold valid and payload stable until ready. Dropping valid before ready withdraws the request; this is legal.
- Error check is on the latched address: `addr[1:0] != 0` or `addr[31:ADDR_BITS] != 0` gives err = 1.
  - On error, ACCESS drives no strobes, rdata = 0, err = 1.
- ACCESS with no error:
  - `mem_addr` = latched addr; `mem_w_data` = latched wdata.
  - `mem_w_enb` = we; `mem_r_enb` = !we.
  - On a read, `mem_r_data` is captured into the rdata register at the end of the cycle.
- RESP: `rvalid` = 1 on the latched port only. rdata and err are driven from registers; the other port's outputs are 0.
- Outside ACCESS, all `mem_*` outputs are 0.

## Timing
- Request handshake in cycle N:
  - Memory is strobed in cycle N+1; the write commits at the end of N+1.
  - `rvalid` is asserted in cycle N+2.
  - Next `ready` is possible in cycle N+3.
- Throughput: one transaction per 3 cycles.
- Reset values: state IDLE, `last_grant` = 1, both `ready` = 0, both `rvalid` = 0, both `err` = 0, both `rdata` = 0, all `mem_*` = 0.
- `rst` high in any cycle:
  - `mem_w_enb` and `mem_r_enb` are forced to 0 that cycle.
  - The in-flight transaction is dropped with no response.
  - The next cycle is IDLE with reset values.
- A request arriving while in ACCESS or RESP waits; it is not lost. Fairness is re-evaluated on the next IDLE.
- Read-after-write from the other port returns the new data: the write commits at the end of ACCESS, before the next read's ACCESS cycle.

## Structure
- Shared package `mem_arb_pkg`:
  - State encoding: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2.
  - Port index constants: PORT_IF = 0, PORT_LS = 1.
- Sub-module `rr_arb2`: 2-input round-robin picker. Inputs are the two valids and `last_grant`; outputs are the grant index and `any_valid`. It is purely combinational; `last_grant` is held in `mem_arbiter`.

## Test plan
- Reset, then port 0 writes addr 0x10, data 0xDEADBEEF. Required: `m0_ready` in cycle N; `mem_w_enb` = 1 with `mem_addr` = 0x10 in N+1; `m0_rvalid` = 1 and `m0_err` = 0 in N+2.
- Port 1 reads addr 0x10 after the previous write. Required: `m1_rdata` = 0xDEADBEEF, `m1_err` = 0 at `m1_rvalid`, 2 cycles after the handshake.
- Both ports continuously request reads from addr 0x0 and 0x4. Required: grants go 0, 1, 0, 1; one handshake every 3 cycles; the two ready signals are never high together.
- Port 1 reads addr 0x12, then addr 0x400 with `ADDR_BITS` = 10. Required: for each, `m1_err` = 1, `m1_rdata` = 0, no memory strobe in ACCESS.
- Port 0 write accepted, `rst` asserted during the ACCESS cycle. Required: `mem_w_enb` = 0 that cycle; no `m0_rvalid`; IDLE next cycle; port 0 wins the next tie.
- `m1_valid` raised while port 0 is in ACCESS. Required: `m1_ready` only in the following IDLE cycle; response is correct.
